// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared width helper and default timing constants for key_conditioner.
// Rev 1.0
`default_nettype none

package key_cond_pkg;

  localparam int DEB_5MS_50MHZ   = 250000;
  localparam int REP_250MS_50MHZ = 12500000;

  // $clog2 that never collapses to a zero-width vector
  function automatic int clog2_min1(input int value);
    return ($clog2(value) < 1) ? 1 : $clog2(value);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_cond_channel.sv
// key_cond_channel: sync, debounce, press/release pulses and auto-repeat for one input.
// Rev 1.0
`default_nettype none

module key_cond_channel
  import key_cond_pkg::*;
#(
  parameter logic ACTIVE_LOW      = 1'b1,
  parameter int   DEBOUNCE_CYCLES = DEB_5MS_50MHZ,
  parameter int   REPEAT_DELAY    = 0,
  parameter int   REPEAT_PERIOD   = REP_250MS_50MHZ
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level,
  output logic press,
  output logic release_out
);

  localparam int CW        = clog2_min1(DEBOUNCE_CYCLES + 1);
  localparam bit REPEAT_EN = (REPEAT_DELAY > 0) && (REPEAT_PERIOD > 0);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          rep_hit;

  always_comb begin
    s1_d     = raw_in ^ ACTIVE_LOW;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // any sample equal to the accepted level restarts the count
    if (s2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d = (stable_d & ~stable_q) | rep_hit;
    rel_d   = ~stable_d & stable_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  generate
    if (REPEAT_EN) begin : g_repeat
      localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW   = clog2_min1(RMAX + 1);

      logic [RW-1:0] rcnt_q, rcnt_d;
      logic [RW-1:0] rcnt_inc, rcnt_tgt;
      logic          period_q, period_d;
      logic          hit;

      // first target is the delay; after the first hit the period applies
      always_comb begin
        rcnt_inc = rcnt_q + RW'(1);
        rcnt_tgt = period_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
        rcnt_d   = rcnt_q;
        period_d = period_q;
        hit      = 1'b0;
        if (!stable_d) begin
          rcnt_d   = '0;
          period_d = 1'b0;
        end else if (stable_q) begin
          if (rcnt_inc == rcnt_tgt) begin
            hit      = 1'b1;
            rcnt_d   = '0;
            period_d = 1'b1;
          end else begin
            rcnt_d = rcnt_inc;
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rcnt_q   <= '0;
          period_q <= 1'b0;
        end else begin
          rcnt_q   <= rcnt_d;
          period_q <= period_d;
        end
      end

      assign rep_hit = hit;
    end else begin : g_no_repeat
      assign rep_hit = 1'b0;
    end
  endgenerate

  assign level       = stable_q;
  assign press       = press_q;
  assign release_out = rel_q;

endmodule

`default_nettype wire

// File: rtl/key_conditioner.sv
// key_conditioner: N independent input-conditioning channels feeding the game/light FSMs.
// Rev 1.0
`default_nettype none

module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int           N               = 4,
  parameter logic [N-1:0] ACTIVE_LOW      = {N{1'b1}},
  parameter int           DEBOUNCE_CYCLES = DEB_5MS_50MHZ,
  parameter int           REPEAT_DELAY    = 0,
  parameter int           REPEAT_PERIOD   = REP_250MS_50MHZ
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_out
);

  generate
    for (genvar i = 0; i < N; i++) begin : g_chan
      key_cond_channel #(
        .ACTIVE_LOW      (ACTIVE_LOW[i]),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
        .clk         (clk),
        .reset       (reset),
        .raw_in      (raw_in[i]),
        .level       (level[i]),
        .press       (press[i]),
        .release_out (release_out[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scoreboard bench for key_conditioner (N=2, debounce 4, repeat 10/5).
// Rev 1.0
`default_nettype none

module tb_key_conditioner;

  logic       clk;
  logic       reset;
  logic [1:0] raw_in;
  logic [1:0] raw2;
  logic [1:0] level, press, rel;
  logic [1:0] level2, press2, rel2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int p2_cnt0  = 0;
  int p2_cnt1  = 0;
  int r2_cnt   = 0;

  typedef struct {
    int         cyc;
    logic [1:0] p;
    logic [1:0] r;
  } evt_t;

  evt_t sb[$];

  key_conditioner #(
    .N(2), .ACTIVE_LOW(2'b01), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .level(level), .press(press), .release_out(rel)
  );

  key_conditioner #(
    .N(2), .ACTIVE_LOW(2'b01), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(5)
  ) dut_norep (
    .clk(clk), .reset(reset), .raw_in(raw2),
    .level(level2), .press(press2), .release_out(rel2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest pending event
  always @(posedge clk) begin
    evt_t e;
    #1;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      check_eq("missed_event", 32'(cyc), 32'(sb[0].cyc));
      void'(sb.pop_front());
    end
    if ((press | rel) != 2'b00) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", {28'd0, press, rel}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("event_cycle", 32'(cyc), 32'(e.cyc));
        check_eq("event_press", {30'd0, press}, {30'd0, e.p});
        check_eq("event_release", {30'd0, rel}, {30'd0, e.r});
      end
    end
    if (press2[0]) p2_cnt0++;
    if (press2[1]) p2_cnt1++;
    r2_cnt += int'(rel2[0]) + int'(rel2[1]);
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // A change driven now is sampled on edge cyc+1 and accepted on edge cyc+6
  task automatic drive(input logic [1:0] v, input logic [1:0] p, input logic [1:0] r);
    evt_t e;
    raw_in = v;
    if ((p | r) != 2'b00) begin
      e.cyc = cyc + 6;
      e.p   = p;
      e.r   = r;
      sb.push_back(e);
    end
  endtask

  task automatic push_evt(input int c, input logic [1:0] p, input logic [1:0] r);
    evt_t e;
    e.cyc = c;
    e.p   = p;
    e.r   = r;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    reset  = 1'b1;
    raw_in = 2'b10;
    raw2   = 2'b01;
    #1 reset = 1'b0;

    // reset held with both channels logically active
    repeat (5) @(negedge clk);
    check_eq("rst_level", {30'd0, level}, 32'd0);
    check_eq("rst_press", {30'd0, press}, 32'd0);
    check_eq("rst_release", {30'd0, rel}, 32'd0);
    check_eq("rst_level_norep", {30'd0, level2}, 32'd0);
    reset = 1'b1;
    t = cyc;
    push_evt(t + 6, 2'b11, 2'b00);
    wait_cyc(t + 5);
    check_eq("rst_level_before", {30'd0, level}, 32'd0);
    wait_cyc(t + 6);
    check_eq("rst_level_after", {30'd0, level}, 32'd3);
    wait_cyc(t + 7);
    drive(2'b01, 2'b00, 2'b11);
    wait_cyc(t + 16);

    // clean press and release on channel 1
    t = cyc;
    drive(2'b11, 2'b10, 2'b00);
    wait_cyc(t + 6);
    check_eq("deb_level_high", {30'd0, level}, 32'd2);
    wait_cyc(t + 8);
    drive(2'b01, 2'b00, 2'b10);
    wait_cyc(t + 14);
    check_eq("deb_level_low", {30'd0, level}, 32'd0);
    wait_cyc(t + 18);

    // 3-cycle glitches never reach the output
    for (int g = 0; g < 5; g++) begin
      drive(2'b11, 2'b00, 2'b00);
      repeat (3) @(negedge clk);
      drive(2'b01, 2'b00, 2'b00);
      repeat (2) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check_eq("glitch_level", {30'd0, level}, 32'd0);

    // auto-repeat: pulses at L, L+10, L+15, L+20, L+25; level falls at L+30
    t = cyc;
    drive(2'b11, 2'b10, 2'b00);
    push_evt(t + 16, 2'b10, 2'b00);
    push_evt(t + 21, 2'b10, 2'b00);
    push_evt(t + 26, 2'b10, 2'b00);
    push_evt(t + 31, 2'b10, 2'b00);
    wait_cyc(t + 20);
    check_eq("rep_level_held", {30'd0, level}, 32'd2);
    wait_cyc(t + 30);
    drive(2'b01, 2'b00, 2'b10);
    wait_cyc(t + 36);
    check_eq("rep_level_low", {30'd0, level}, 32'd0);
    wait_cyc(t + 46);

    // reset in the middle of a debounce, input still active afterwards
    drive(2'b11, 2'b00, 2'b00);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("midrst_level", {30'd0, level}, 32'd0);
    check_eq("midrst_press", {30'd0, press}, 32'd0);
    reset = 1'b1;
    t = cyc;
    push_evt(t + 6, 2'b10, 2'b00);
    wait_cyc(t + 6);
    check_eq("midrst_level_after", {30'd0, level}, 32'd2);
    wait_cyc(t + 8);
    drive(2'b01, 2'b00, 2'b10);
    wait_cyc(t + 18);

    // both channels change on the same cycle
    t = cyc;
    drive(2'b10, 2'b11, 2'b00);
    wait_cyc(t + 6);
    check_eq("indep_level", {30'd0, level}, 32'd3);
    wait_cyc(t + 8);
    drive(2'b01, 2'b00, 2'b11);
    wait_cyc(t + 18);

    // build without auto-repeat: one press per long hold
    raw2 = 2'b10;
    repeat (40) @(negedge clk);
    check_eq("norep_level", {30'd0, level2}, 32'd3);
    check_eq("norep_press_ch0", 32'(p2_cnt0), 32'd1);
    check_eq("norep_press_ch1", 32'(p2_cnt1), 32'd1);
    raw2 = 2'b01;
    repeat (8) @(negedge clk);
    check_eq("norep_level_low", {30'd0, level2}, 32'd0);
    check_eq("norep_release", 32'(r2_cnt), 32'd2);

    repeat (5) @(negedge clk);
    check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
